tone_scheduler: RTL
===================

Name: tone_scheduler

Overview:
- Shares the single speaker tone generator of the game controller among NUM_REQ independent sound requesters, e.g. game FSM, key-click unit and win/loss sequencer.
- Fixed-priority arbitration, index 0 highest, with optional preemption.
- Times each granted tone for a requested duration, inserts a silent gap between tones, and produces the square-wave speaker output.
- Sits between the game-control FSMs and the speaker pin.

Parameters:
- NUM_REQ, 3, number of requesters, 2..4.
- DUR_W, 6, width of each duration field.
- GAP_CYCLES, 2, silent cycles forced after a tone completes, 1..15.
- PREEMPT, 1, 1 = a higher-priority request aborts the tone in progress; 0 = run to completion.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; all state to reset values immediately.
- req  in  NUM_REQ  request per requester; level, held until gnt.
- code  in  3*NUM_REQ  sound code per requester, slice i = [3i+2:3i].
- dur  in  DUR_W*NUM_REQ  tone length per requester; tone lasts dur+1 cycles.
- gnt  out  NUM_REQ  one-cycle pulse, request accepted.
- done  out  NUM_REQ  one-cycle pulse, tone finished normally.
- abort  out  NUM_REQ  one-cycle pulse, tone preempted.
- owner  out  2  index of current owner; valid while busy.
- busy  out  1  high in PLAY and GAP.
- speaker  out  1  square-wave output.

Behaviour:
- Reset values: gnt/done/abort = 0, owner = 0, busy = 0, speaker = 0, state IDLE, tone counter = 0, phase = 0.
- Reset asserted mid-tone: the tone is dropped silently, with no done and no abort pulse.
- States: IDLE, PLAY, GAP.
- IDLE:
  - At an edge with req != 0, select the lowest set index i.
  - Latch code[i], dur[i]; owner = i; gnt[i] = 1 for the following cycle; state becomes PLAY.
  - Grant latency is 1 cycle after req is sampled.
- Requester obligation: drop req in the cycle gnt is seen. Any req still high when the scheduler re-enters IDLE is a new request.
- PLAY:
  - remaining counter loaded with dur and decremented each cycle.
  - At the edge where remaining == 0: done[owner] pulses the next cycle and state becomes GAP.
  - PLAY therefore lasts exactly dur+1 cycles; dur = 0 gives a 1-cycle tone.
- GAP:
  - speaker forced 0 for GAP_CYCLES cycles, then IDLE.
  - Requests are not sampled during GAP.
- Preemption (PREEMPT = 1):
  - In PLAY, if req[j] = 1 for some j < owner at an edge: abort[owner] pulses next cycle and gnt[j] pulses in that same cycle.
  - State stays PLAY with the new code/dur/owner. No gap is inserted.
  - Equal- or lower-priority requests wait.
  - With PREEMPT = 0, all requests are ignored in PLAY.
- Tone generator thresholds T by code: 0→2, 1→3, 2→4, 3→5, 4 (win)→6, 5 (loss)→1; codes 6 and 7 are silent.
- Tone generator, each PLAY cycle:
  - If counter > T: phase = ~phase, speaker = new phase, counter = 0.
  - Otherwise counter = counter + 1, a 3-bit increment.
  - The speaker therefore toggles every T+2 PLAY cycles; half period = T+2.
  - Silent codes hold counter = 0 and speaker = 0.
- On every grant, including preemption: counter = 0, phase = 0, speaker = 0.
- Outside PLAY: counter = 0, speaker = 0.
- Invariants: speaker == 0 whenever busy == 0; at most one bit of gnt|done|abort set in any cycle, except during preemption, where exactly one abort bit and one gnt bit are set; gnt never issued while busy unless preempting.
- Simultaneous events: new requests arriving at the tone's final edge are not sampled. They are served after GAP, lowest index first.

Test Plan:
- req[0] with code 0, dur 9 from IDLE → gnt[0] 1 cycle later; speaker rises after PLAY cycle 4 and falls after cycle 8; done[0] after PLAY cycle 10; busy low 2 cycles after done.
- req[1] and req[2] asserted in the same cycle, both with code 3, dur 5 → gnt[1] first; gnt[2] only after done[1] plus 2 gap cycles.
- PREEMPT = 1: req[2] playing code 4, dur 40; req[0] (code 5, dur 3) asserted at PLAY cycle 10 → abort[2] and gnt[0] in the same cycle; speaker 0 that cycle; loss tone toggles every 3 cycles; done[0] after 4 cycles; no done[2].
- PREEMPT = 0, same stimulus → no abort; done[2] after 41 PLAY cycles; gnt[0] after the gap.
- Code 6, dur 7 → speaker stays 0 for all 8 PLAY cycles; done pulses normally.
- Reset asserted during PLAY cycle 5 → all outputs 0 immediately with no done or abort pulse; after release, a held req gets gnt on the cycle following the next edge.

Source files
------------

// File: rtl/tone_scheduler_if.sv
// Requester-side bus of the tone scheduler: requests, tone parameters,
// handshake pulses and the speaker output.
interface tone_scheduler_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DUR_W   = 6
);
  logic [NUM_REQ-1:0]       req;
  logic [3*NUM_REQ-1:0]     code;
  logic [DUR_W*NUM_REQ-1:0] dur;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       done;
  logic [NUM_REQ-1:0]       abort;
  logic [1:0]               owner;
  logic                     busy;
  logic                     speaker;

  modport master (
    output req, code, dur,
    input  gnt, done, abort, owner, busy, speaker
  );

  modport slave (
    input  req, code, dur,
    output gnt, done, abort, owner, busy, speaker
  );
endinterface

// File: rtl/tone_scheduler.sv
// Shares one square-wave tone generator among NUM_REQ requesters with
// fixed priority (index 0 highest), optional preemption, per-tone duration
// timing and a forced silent gap after each completed tone.
module tone_scheduler #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned DUR_W      = 6,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned PREEMPT    = 1
) (
  input logic             clock,
  input logic             reset,
  tone_scheduler_if.slave bus
);

  localparam int unsigned OWN_W  = 2;
  localparam int unsigned CODE_W = 3;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned GAP_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state_q, nxt_state;
  logic [OWN_W-1:0]   owner_q, nxt_owner;
  logic [CODE_W-1:0]  code_q, nxt_code;
  logic [DUR_W-1:0]   rem_q, nxt_rem;
  logic [GAP_W-1:0]   gap_q, nxt_gap;
  logic [NUM_REQ-1:0] gnt_q, nxt_gnt;
  logic [NUM_REQ-1:0] done_q, nxt_done;
  logic [NUM_REQ-1:0] abort_q, nxt_abort;
  logic               busy_q, nxt_busy;
  logic [CNT_W-1:0]   tcnt_q, nxt_tcnt;
  logic               phase_q, nxt_phase;
  logic               spk_q, nxt_spk;

  logic               any_req, any_pre, start;
  logic [OWN_W-1:0]   pick_idx, pre_idx, start_idx;

  // Half-period threshold per sound code (codes 6/7 are silent).
  function automatic logic [CNT_W-1:0] thr_of(input logic [CODE_W-1:0] c);
    case (c)
      3'd0:    thr_of = 3'd2;
      3'd1:    thr_of = 3'd3;
      3'd2:    thr_of = 3'd4;
      3'd3:    thr_of = 3'd5;
      3'd4:    thr_of = 3'd6;
      3'd5:    thr_of = 3'd1;
      default: thr_of = 3'd0;
    endcase
  endfunction

  function automatic logic is_silent(input logic [CODE_W-1:0] c);
    is_silent = (c[2:1] == 2'b11);
  endfunction

  // Lowest-index request overall, and lowest-index request above the owner.
  always_comb begin
    any_req  = 1'b0;
    pick_idx = '0;
    any_pre  = 1'b0;
    pre_idx  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (bus.req[i] && !any_req) begin
        any_req  = 1'b1;
        pick_idx = OWN_W'(i);
      end
      if (bus.req[i] && (OWN_W'(i) < owner_q) && !any_pre) begin
        any_pre = 1'b1;
        pre_idx = OWN_W'(i);
      end
    end
  end

  // Next-state, grant/latch, pulse and tone-generator logic.
  always_comb begin
    nxt_state = state_q;
    nxt_owner = owner_q;
    nxt_code  = code_q;
    nxt_rem   = rem_q;
    nxt_gap   = gap_q;
    nxt_gnt   = '0;
    nxt_done  = '0;
    nxt_abort = '0;
    start     = 1'b0;
    start_idx = pick_idx;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          start     = 1'b1;
          start_idx = pick_idx;
          nxt_state = PLAY;
        end
      end
      PLAY: begin
        // Normal completion wins over a same-edge preemption request.
        if (rem_q == '0) begin
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (OWN_W'(i) == owner_q) nxt_done[i] = 1'b1;
          end
          nxt_state = GAP;
          nxt_gap   = GAP_W'(GAP_CYCLES - 1);
        end else if ((PREEMPT != 0) && any_pre) begin
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (OWN_W'(i) == owner_q) nxt_abort[i] = 1'b1;
          end
          start     = 1'b1;
          start_idx = pre_idx;
        end else begin
          nxt_rem = rem_q - DUR_W'(1);
        end
      end
      GAP: begin
        if (gap_q == '0) nxt_state = IDLE;
        else             nxt_gap   = gap_q - GAP_W'(1);
      end
      default: nxt_state = IDLE;
    endcase

    // Grant: latch the winner's code and duration.
    if (start) begin
      nxt_owner = start_idx;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (OWN_W'(i) == start_idx) begin
          nxt_gnt[i] = 1'b1;
          nxt_code   = bus.code[CODE_W*i +: CODE_W];
          nxt_rem    = bus.dur[DUR_W*i +: DUR_W];
        end
      end
    end

    nxt_busy = (nxt_state != IDLE);

    // Tone generator only advances while a tone keeps playing; grants and
    // every non-PLAY cycle clear it.
    nxt_tcnt  = '0;
    nxt_phase = 1'b0;
    nxt_spk   = 1'b0;
    if ((state_q == PLAY) && (nxt_state == PLAY) && !start && !is_silent(code_q)) begin
      if (tcnt_q > thr_of(code_q)) begin
        nxt_tcnt  = '0;
        nxt_phase = ~phase_q;
        nxt_spk   = ~phase_q;
      end else begin
        nxt_tcnt  = tcnt_q + CNT_W'(1);
        nxt_phase = phase_q;
        nxt_spk   = spk_q;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      code_q  <= '0;
      rem_q   <= '0;
      gap_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      abort_q <= '0;
      busy_q  <= 1'b0;
      tcnt_q  <= '0;
      phase_q <= 1'b0;
      spk_q   <= 1'b0;
    end else begin
      state_q <= nxt_state;
      owner_q <= nxt_owner;
      code_q  <= nxt_code;
      rem_q   <= nxt_rem;
      gap_q   <= nxt_gap;
      gnt_q   <= nxt_gnt;
      done_q  <= nxt_done;
      abort_q <= nxt_abort;
      busy_q  <= nxt_busy;
      tcnt_q  <= nxt_tcnt;
      phase_q <= nxt_phase;
      spk_q   <= nxt_spk;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.abort   = abort_q;
  assign bus.owner   = owner_q;
  assign bus.busy    = busy_q;
  assign bus.speaker = spk_q;

`ifndef SYNTHESIS
  // Speaker is silent whenever the scheduler is idle.
  a_spk_idle : assert property (@(posedge clock) disable iff (reset)
    !busy_q |-> !spk_q);
  // Outside preemption at most one handshake pulse per cycle.
  a_one_evt : assert property (@(posedge clock) disable iff (reset)
    (abort_q == '0) |-> $onehot0(gnt_q | done_q));
  // A preemption pairs exactly one abort with exactly one grant.
  a_preempt : assert property (@(posedge clock) disable iff (reset)
    (abort_q != '0) |-> ($onehot(abort_q) && $onehot(gnt_q) && (done_q == '0)));
`endif

endmodule
